serial_addsub_ctrl: RTL and testbench
=====================================

# serial_addsub_ctrl

Bit-serial add/subtract sequencer that drives a single 1-bit full-adder/subtractor cell over WIDTH-bit operands, LSB first, one bit per clock. It sits between a requester using a start/done handshake and the shared 1-bit arithmetic cell. It owns carry sequencing, subtract-mode carry injection, bit counting and result/flag capture.

## Interface
- WIDTH, 8, operand and result width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = add (A+B), 1 = subtract (A−B, two's complement); latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds until next done.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start=1 at a rising edge:
  - Latch a, b, mode into operand shift registers.
  - carry ← mode (subtract injects +1).
  - bit count ← 0.
  - Go to RUN.
- IDLE, start=0: stay.
- RUN, each edge: feed bit i of a, bit i of b, mode and carry to the cell.
  - s_i = a_i ^ b_i ^ mode ^ carry.
  - carry' = ((b_i ^ mode) & a_i) | ((a_i ^ b_i ^ mode) & carry).
  - Shift s_i into the working result register from the MSB side.
  - Shift operands right.
  - Count increments.
- RUN exit: on the edge that processes bit WIDTH−1, go to DONE. On that same edge:
  - sum ← completed working result.
  - cout ← carry'.
  - overflow ← carry-in of bit WIDTH−1 XOR carry'.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while in RUN or DONE is ignored. It is neither queued nor re-sampled. The requester must re-assert start in IDLE.
- a, b and mode may change freely after the accepting edge.
- The working register never drives sum directly. sum, cout and overflow change only on entry to DONE.
- Reset (any time, including mid-RUN):
  - state = IDLE; busy, done, sum, cout, overflow = 0.
  - Counter, carry and working registers cleared.
  - An aborted operation produces no done.
- Wrap-around: arithmetic is modulo 2^WIDTH. Carry/borrow is reported only through cout; signed wrap is reported only through overflow.

## Timing
- start sampled at edge k.
- busy is high after edges k … k+WIDTH−1, i.e. WIDTH cycles.
- done is high for the single cycle after edge k+WIDTH. Latency start→done = WIDTH cycles.
- sum, cout and overflow are valid from edge k+WIDTH onward and remain stable until the next DONE entry.
- Earliest next accepted start: edge k+WIDTH+2 (the first IDLE edge). Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package addsub_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE (2 bits).
  - MODE_ADD = 0, MODE_SUB = 1.
- Counter width is $clog2(WIDTH), local to the block.
- One sub-module: addsub_cell.
  - Purely combinational 1-bit full adder/subtractor with inputs a, b, cin, mode and outputs s, cout. Equations as above.
  - Instantiated once.
  - The controller holds all state.

## Test plan
- Add, WIDTH=8: a=0x35, b=0x4A, mode=0 → done exactly 8 cycles after start; sum=0x7F, cout=0, overflow=0.
- Add with overflow and carry:
  - a=0x7F, b=0x01, mode=0 → sum=0x80, cout=0, overflow=1.
  - a=0xFF, b=0x01, mode=0 → sum=0x00, cout=1, overflow=0.
- Subtract:
  - a=0x10, b=0x20, mode=1 → sum=0xF0, cout=0 (borrow), overflow=0.
  - a=0x80, b=0x01, mode=1 → sum=0x7F, cout=1, overflow=1.
- Handshake:
  - start held high for 12 cycles with a=0x01, b=0x01 → first op accepted; sum=0x02; a second op is accepted only at the first IDLE edge.
  - Operands changed during RUN do not alter the result.
  - busy is high for exactly 8 cycles; done is a 1-cycle pulse.
- Reset mid-operation:
  - rst_n low during RUN bit 4 → busy, done, sum, cout, overflow = 0 immediately, no done pulse.
  - After release, a=0x03, b=0x04, mode=0 → sum=0x07 with normal latency.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_e  : controller state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   MODE_ADD : mode value selecting A+B
//   MODE_SUB : mode value selecting A-B (two's complement)
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Requester-side bus of the bit-serial add/subtract sequencer.
//   start, mode, a, b              : request, driven by the master
//   busy, done, sum, cout, overflow : status and result, driven by the slave
interface serial_addsub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_ctrl_cell.sv
// addsub_cell: purely combinational 1-bit full adder/subtractor.
//   a, b : operand bits
//   cin  : carry in
//   mode : 0 = add, 1 = subtract (b is inverted)
//   s    : sum bit
//   cout : carry out
module addsub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);
    logic b_eff;

    assign b_eff = b ^ mode;
    assign s     = a ^ b_eff ^ cin;
    assign cout  = (b_eff & a) | ((a ^ b_eff) & cin);
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer. Latches operands on start, feeds them LSB first
// through one shared addsub_cell, one bit per clock, then pulses done with the result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_addsub_ctrl_if (start/mode/a/b in; busy/done/sum/cout/
//           overflow out, all registered)
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 low result bits; the final bit comes straight from the cell.
    logic [WIDTH-2:0] work;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             carry_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             overflow_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] work_ext;

    addsub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .mode (mode_q),
        .s    (s_bit),
        .cout (c_bit)
    );

    // New bit enters from the MSB side; on the last bit this is the completed result.
    assign work_ext = {s_bit, work};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            work       <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        mode_q  <= bus.mode;
                        // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                        carry_q <= (bus.mode == MODE_SUB);
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    work    <= work_ext[WIDTH-1:1];
                    carry_q <= c_bit;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        sum_q      <= work_ext;
                        cout_q     <= c_bit;
                        // carry_q is the carry into the MSB at this point.
                        overflow_q <= carry_q ^ c_bit;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH = 8).
module tb_serial_addsub_ctrl;
    import addsub_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; lat counts edges after acceptance.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                          output int lat, output int busy_cnt, output bit found);
        bus.a     = av;
        bus.b     = bv;
        bus.mode  = mv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        found     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.mode  = MODE_ADD;
        rst_n     = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        bit found;
        run_op(8'h35, 8'h4A, MODE_ADD, lat, bc, found);
        total++;
        if (!found) begin bad++; $display("FAIL add_done: no done within bound"); end
        total++;
        if (lat !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
        total++;
        if (bus.sum !== 8'h7F) begin bad++; $display("FAIL add_sum: got %h want 7f", bus.sum); end
        total++;
        if (bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL add_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.overflow);
        end
        step();
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_add_overflow();
        int lat, bc;
        bit found;
        run_op(8'h7F, 8'h01, MODE_ADD, lat, bc, found);
        total++;
        if (!found || bus.sum !== 8'h80) begin
            bad++;
            $display("FAIL ovf_sum: got %h done=%b want 80", bus.sum, found);
        end
        total++;
        if (bus.cout !== 1'b0 || bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flags: got cout=%b ovf=%b want 0 1", bus.cout, bus.overflow);
        end
        step();
        run_op(8'hFF, 8'h01, MODE_ADD, lat, bc, found);
        total++;
        if (!found || bus.sum !== 8'h00) begin
            bad++;
            $display("FAIL carry_sum: got %h done=%b want 00", bus.sum, found);
        end
        total++;
        if (bus.cout !== 1'b1 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL carry_flags: got cout=%b ovf=%b want 1 0", bus.cout, bus.overflow);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [11:0] busy_pat;
        logic [11:0] done_pat;
        logic [7:0]  sum_at_done;
        int          lat;
        bit          found;
        busy_pat    = '0;
        done_pat    = '0;
        sum_at_done = '0;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.mode  = MODE_ADD;
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            busy_pat[i] = bus.busy;
            done_pat[i] = bus.done;
            if (bus.done) sum_at_done = bus.sum;
        end
        bus.start = 1'b0;
        // Second op is already running; these must not reach its result.
        bus.a     = 8'hF0;
        bus.b     = 8'h0F;
        bus.mode  = MODE_SUB;
        total++;
        if (busy_pat !== 12'b1100_1111_1111) begin
            bad++;
            $display("FAIL b2b_busy_pattern: got %b want 110011111111", busy_pat);
        end
        total++;
        if (done_pat !== 12'b0001_0000_0000) begin
            bad++;
            $display("FAIL b2b_done_pattern: got %b want 000100000000", done_pat);
        end
        total++;
        if (sum_at_done !== 8'h02) begin
            bad++;
            $display("FAIL b2b_first_sum: got %h want 02", sum_at_done);
        end
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            step();
            lat++;
        end
        total++;
        if (!found || lat !== 7) begin
            bad++;
            $display("FAIL b2b_second_latency: got %0d done=%b want 7", lat, found);
        end
        total++;
        if (bus.sum !== 8'h02 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_result: got sum=%h cout=%b ovf=%b want 02 0 0",
                     bus.sum, bus.cout, bus.overflow);
        end
        step();
    endtask

    task automatic test_sub();
        int lat, bc;
        bit found;
        run_op(8'h10, 8'h20, MODE_SUB, lat, bc, found);
        total++;
        if (!found || bus.sum !== 8'hF0) begin
            bad++;
            $display("FAIL sub_borrow_sum: got %h done=%b want f0", bus.sum, found);
        end
        total++;
        if (bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.overflow);
        end
        step();
        run_op(8'h80, 8'h01, MODE_SUB, lat, bc, found);
        total++;
        if (!found || bus.sum !== 8'h7F) begin
            bad++;
            $display("FAIL sub_ovf_sum: got %h done=%b want 7f", bus.sum, found);
        end
        total++;
        if (bus.cout !== 1'b1 || bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf_flags: got cout=%b ovf=%b want 1 1", bus.cout, bus.overflow);
        end
        // Result must hold while idle even with new operands on the bus.
        bus.a = 8'hAA;
        bus.b = 8'h55;
        repeat (4) step();
        total++;
        if (bus.sum !== 8'h7F || bus.cout !== 1'b1 || bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_hold: got sum=%h cout=%b ovf=%b want 7f 1 1",
                     bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, done_cnt;
        bit found;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        bus.mode  = MODE_ADD;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        step();
        step();
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done || bus.busy) done_cnt++;
        end
        total++;
        if (done_cnt !== 0) begin
            bad++;
            $display("FAIL mid_no_done: got %0d active cycles want 0", done_cnt);
        end
        run_op(8'h03, 8'h04, MODE_ADD, lat, bc, found);
        total++;
        if (!found || lat !== 8) begin
            bad++;
            $display("FAIL post_reset_latency: got %0d done=%b want 8", lat, found);
        end
        total++;
        if (bus.sum !== 8'h07 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_result: got sum=%h cout=%b ovf=%b want 07 0 0",
                     bus.sum, bus.cout, bus.overflow);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_back_to_back();
        test_sub();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
